// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-path definitions: bus width defaults common with the program
// counter, plus the fetch FSM state encoding.
package instr_fetch_queue_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; head entry is shown on rdata.
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_eff;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_eff = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop_eff})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: accepts PC addresses, issues one memory read at a
// time over req/ack, and buffers returned words for decode; redirect flushes.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic              ins_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic                     accept;
    logic                     push;
    logic                     pop;

    assign pc_ready = (state_q == IDLE) && (fifo_count < CW'(DEPTH)) && !redirect;
    assign accept   = pc_valid & pc_ready;
    // Only a WAIT-state beat carries live data; DROP beats and redirected beats are discarded.
    assign push     = (state_q == WAIT) & mem_ack & ~redirect & ~fifo_full;
    assign pop      = ~fifo_empty & ins_ready & ~redirect;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d = pc_addr;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem_addr_q, mem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ins_valid = ~fifo_empty;
    assign ins_addr  = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
    assign ins_data  = fifo_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic, all
// checked against a transaction-level model (outstanding flag + entry queue).
module tb_instr_fetch_queue;

    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 20;
    localparam int unsigned DEPTH = 2;

    logic          clock;
    logic          reset;
    logic [AW-1:0] pc_addr;
    logic          pc_valid;
    logic          pc_ready;
    logic          redirect;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ins_valid;
    logic [DW-1:0] ins_data;
    logic [AW-1:0] ins_addr;
    logic          ins_ready;

    instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .pc_valid  (pc_valid),
        .pc_ready  (pc_ready),
        .redirect  (redirect),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ins_addr  (ins_addr),
        .ins_ready (ins_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: one outstanding read (busy), whether its data is doomed (dropping),
    // the last issued address, and the queued {addr, data} entries.
    logic [AW+DW-1:0] q[$];
    bit               busy;
    bit               dropping;
    logic [AW-1:0]    m_addr;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_pc_ready();
        return !busy && (q.size() < DEPTH) && !redirect;
    endfunction

    task automatic model_reset();
        q.delete();
        busy     = 1'b0;
        dropping = 1'b0;
        m_addr   = '0;
    endtask

    task automatic model_update();
        bit acc;
        bit beat;
        bit do_push;
        acc     = pc_valid && exp_pc_ready();
        beat    = busy && mem_ack;
        do_push = beat && !dropping && !redirect;
        if (beat) begin
            busy     = 1'b0;
            dropping = 1'b0;
        end else if (busy && redirect) begin
            dropping = 1'b1;
        end
        if (redirect) begin
            q.delete();
        end else begin
            if (ins_ready && q.size() > 0) void'(q.pop_front());
            if (do_push) q.push_back({m_addr, mem_rdata});
        end
        if (acc) begin
            busy   = 1'b1;
            m_addr = pc_addr;
        end
    endtask

    task automatic check_outputs();
        logic [AW+DW-1:0] head;
        chk("pc_ready", pc_ready, exp_pc_ready());
        chk("mem_req", mem_req, busy);
        chk("mem_addr", mem_addr, m_addr);
        chk("ins_valid", ins_valid, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            chk("ins_addr", ins_addr, head[AW+DW-1:DW]);
            chk("ins_data", ins_data, head[DW-1:0]);
        end
    endtask

    task automatic drive(input bit pv, input logic [AW-1:0] pa, input bit rd,
                         input bit ack, input logic [DW-1:0] d, input bit ir);
        pc_valid  = pv;
        pc_addr   = pa;
        redirect  = rd;
        mem_ack   = ack;
        mem_rdata = d;
        ins_ready = ir;
        #1;
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_ins_valid"}, ins_valid, 1'b0);
        chk({tag, "_ins_data"}, ins_data, '0);
        chk({tag, "_ins_addr"}, ins_addr, '0);
        chk({tag, "_pc_ready"}, pc_ready, !redirect);
    endtask

    task automatic random_inputs();
        drive($urandom_range(99) < 60, AW'($urandom), $urandom_range(99) < 8,
              $urandom_range(99) < 40, DW'($urandom), $urandom_range(99) < 50);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        model_reset();
        drive(0, '0, 0, 0, '0, 0);

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            random_inputs();
            check_reset_state("rst");
        end
        @(negedge clock);
        drive(0, '0, 0, 0, '0, 0);
        reset = 1'b1;
        model_reset();

        // Single fetch
        drive(1, 20'h00010, 0, 0, '0, 0);
        chk("sf_pc_ready", pc_ready, 1'b1);
        cycle();
        drive(0, '0, 0, 1, 20'hABCDE, 0);
        chk("sf_mem_req", mem_req, 1'b1);
        chk("sf_mem_addr", mem_addr, 20'h00010);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("sf_ins_valid", ins_valid, 1'b1);
        chk("sf_ins_data", ins_data, 20'hABCDE);
        chk("sf_ins_addr", ins_addr, 20'h00010);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        cycle();

        // Back-pressure: two entries fill the queue, address 2 waits for a pop
        for (int a = 0; a < 2; a++) begin
            drive(1, AW'(a), 0, 0, '0, 0);
            cycle();
            drive(0, '0, 0, 1, DW'(32'h100 + a), 0);
            cycle();
        end
        drive(1, 20'h2, 0, 0, '0, 0);
        chk("bp_full_pc_ready", pc_ready, 1'b0);
        cycle();
        drive(1, 20'h2, 0, 0, '0, 1);
        chk("bp_pop_pc_ready", pc_ready, 1'b0);
        cycle();
        drive(1, 20'h2, 0, 0, '0, 0);
        chk("bp_after_pop_pc_ready", pc_ready, 1'b1);
        cycle();
        drive(0, '0, 0, 1, 20'h00102, 0);
        chk("bp_mem_addr", mem_addr, 20'h2);
        cycle();
        drive(0, '0, 0, 0, '0, 1);
        cycle();
        cycle();

        // Redirect in WAIT with ack three cycles after mem_req rises
        drive(1, 20'h00100, 0, 0, '0, 0);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("rw_mem_req_rise", mem_req, 1'b1);
        cycle();
        drive(0, '0, 1, 0, '0, 0);
        cycle();
        drive(1, 20'h00200, 0, 0, '0, 0);
        chk("rw_drop_pc_ready", pc_ready, 1'b0);
        chk("rw_drop_mem_req", mem_req, 1'b1);
        cycle();
        drive(1, 20'h00200, 0, 1, 20'h55555, 0);
        chk("rw_ack_mem_req", mem_req, 1'b1);
        cycle();
        drive(1, 20'h00200, 0, 0, '0, 0);
        chk("rw_after_mem_req", mem_req, 1'b0);
        chk("rw_after_ins_valid", ins_valid, 1'b0);
        chk("rw_after_pc_ready", pc_ready, 1'b1);
        cycle();
        drive(0, '0, 0, 1, 20'h22222, 0);
        chk("rw_new_mem_addr", mem_addr, 20'h00200);
        cycle();

        // Redirect with a full queue, same-cycle pop and ack
        drive(1, 20'h00300, 0, 0, '0, 0);
        cycle();
        drive(0, '0, 0, 1, 20'h33333, 0);
        cycle();
        drive(1, 20'h00301, 1, 1, 20'h44444, 1);
        chk("rf_pc_ready", pc_ready, 1'b0);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("rf_ins_valid", ins_valid, 1'b0);
        chk("rf_pc_ready_after", pc_ready, 1'b1);
        cycle();

        // Simultaneous push and pop
        drive(1, 20'h00400, 0, 0, '0, 0);
        cycle();
        drive(0, '0, 0, 1, 20'h0AAAA, 0);
        cycle();
        drive(1, 20'h00401, 0, 0, '0, 0);
        cycle();
        drive(0, '0, 0, 1, 20'h0BBBB, 1);
        cycle();
        drive(0, '0, 0, 0, '0, 0);
        chk("pp_ins_valid", ins_valid, 1'b1);
        chk("pp_ins_addr", ins_addr, 20'h00401);
        chk("pp_ins_data", ins_data, 20'h0BBBB);
        chk("pp_pc_ready", pc_ready, 1'b1);
        cycle();

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                random_inputs();
                reset = 1'b0;
                #1;
                check_reset_state("mid_rst");
                @(negedge clock);
                drive(0, '0, 0, 0, '0, 0);
                reset = 1'b1;
                model_reset();
            end
            random_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
